// File: rtl/fp_norm_shift_64.sv
// fp_norm_shift_64: post-adder normalization stage.
// Counts leading zeros of an unnormalized 64-bit mantissa, left-shifts it into
// normalized position and adjusts the biased exponent. When full normalization
// would take the exponent to zero or below, the result is clamped to the
// denormal range instead. Two-stage valid/ready pipeline; results keep input order.

// lza_64: leading-zero count of a 64-bit word, 0..64 (64 for an all-zero word).
// Built as a two-level priority tree: nibbles, then 16-bit groups, then the word.
module lza_64 (
    input  logic [63:0] i_mant,
    output logic [6:0]  o_lzc
);

    logic [15:0]      w_nib_nz;
    logic [1:0]       w_nib_cnt [16];
    logic [3:0]       w_grp_nz;
    logic [3:0]       w_grp_cnt [4];

    // Per-nibble zero flag and leading-zero count; nibble 0 is the most significant.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            logic [3:0] w_nib;
            w_nib        = i_mant[63 - 4 * k -: 4];
            w_nib_nz[k]  = |w_nib;
            if (w_nib[3]) begin
                w_nib_cnt[k] = 2'd0;
            end else if (w_nib[2]) begin
                w_nib_cnt[k] = 2'd1;
            end else if (w_nib[1]) begin
                w_nib_cnt[k] = 2'd2;
            end else begin
                w_nib_cnt[k] = 2'd3;
            end
        end
    end

    // Per-group count: the first nonzero nibble wins, so iterate from the least
    // significant nibble upward and let later (more significant) hits overwrite.
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            w_grp_nz[g]  = |w_nib_nz[4 * g +: 4];
            w_grp_cnt[g] = 4'd0;
            for (int j = 3; j >= 0; j--) begin
                if (w_nib_nz[4 * g + j]) begin
                    w_grp_cnt[g] = 4'(4 * j) + {2'b00, w_nib_cnt[4 * g + j]};
                end
            end
        end
    end

    // Word-level count: same overwrite trick across groups; 64 if nothing is set.
    always_comb begin
        o_lzc = 7'd64;
        for (int g = 3; g >= 0; g--) begin
            if (w_grp_nz[g]) begin
                o_lzc = 7'(16 * g) + {3'b000, w_grp_cnt[g]};
            end
        end
    end

endmodule

module fp_norm_shift_64 #(
    parameter int unsigned EXP_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [63:0]      in_mant,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [63:0]      out_mant,
    output logic [6:0]       out_lzc,
    output logic             out_zero,
    output logic             out_denorm
);

    // Common width for comparing the 7-bit count against the exponent.
    localparam int unsigned CmpW = (EXP_W > 7) ? EXP_W : 7;

    // Stage 1 registers
    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [EXP_W-1:0] r_s1_exp;
    logic [63:0]      r_s1_mant;
    logic [6:0]       r_s1_lzc;

    // Handshake and stage 2 combinational results
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_in_xfer;
    logic [6:0]       w_lzc;
    logic [CmpW-1:0]  w_lzc_ext;
    logic [CmpW-1:0]  w_exp_ext;
    logic [5:0]       w_shift;
    logic [EXP_W-1:0] w_exp_nxt;
    logic [63:0]      w_mant_nxt;
    logic             w_zero_nxt;
    logic             w_denorm_nxt;

    lza_64 u_lza (
        .i_mant (in_mant),
        .o_lzc  (w_lzc)
    );

    // S2 frees up when empty or draining; S1 moves only into a freeing S2.
    // in_ready depends on out_ready and stage state, never on in_valid.
    always_comb begin
        w_s2_adv  = !out_valid || out_ready;
        w_s1_adv  = r_s1_valid && w_s2_adv;
        in_ready  = !r_s1_valid || w_s1_adv;
        w_in_xfer = in_valid && in_ready;
    end

    // Stage 1: capture operand plus its leading-zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_mant  <= '0;
            r_s1_lzc   <= '0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_sign  <= in_sign;
            r_s1_exp   <= in_exp;
            r_s1_mant  <= in_mant;
            r_s1_lzc   <= w_lzc;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    assign w_lzc_ext = CmpW'(r_s1_lzc);
    assign w_exp_ext = CmpW'(r_s1_exp);

    // Shift amount and exponent adjustment, in priority order:
    // zero mantissa, already normalized, normal shift, denormal clamp.
    // The clamp shifts by exp-1 so the value lands where an exponent of 1
    // would put it, which is how the denormal encoding (exp field 0) reads.
    always_comb begin
        w_shift      = 6'd0;
        w_exp_nxt    = r_s1_exp;
        w_zero_nxt   = 1'b0;
        w_denorm_nxt = 1'b0;
        if (r_s1_mant == 64'd0) begin
            w_zero_nxt = 1'b1;
            w_exp_nxt  = '0;
        end else if (r_s1_lzc == 7'd0) begin
            w_shift = 6'd0;
        end else if (w_lzc_ext < w_exp_ext) begin
            w_shift   = r_s1_lzc[5:0];
            w_exp_nxt = EXP_W'(w_exp_ext - w_lzc_ext);
        end else begin
            w_denorm_nxt = 1'b1;
            w_exp_nxt    = '0;
            w_shift      = (r_s1_exp == '0) ? 6'd0 : 6'(w_exp_ext - CmpW'(1));
        end
        w_mant_nxt = r_s1_mant << w_shift;
    end

    // Stage 2: output register; holds while stalled by out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sign   <= 1'b0;
            out_exp    <= '0;
            out_mant   <= '0;
            out_lzc    <= '0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_sign   <= r_s1_sign;
                out_exp    <= w_exp_nxt;
                out_mant   <= w_mant_nxt;
                out_lzc    <= r_s1_lzc;
                out_zero   <= w_zero_nxt;
                out_denorm <= w_denorm_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_shift_64.sv
// Bench for fp_norm_shift_64: directed table, backpressure and reset sequences,
// and a randomized stream checked against a behavioural model.
module tb_fp_norm_shift_64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [10:0] in_exp = '0;
    logic [63:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [10:0] out_exp;
    logic [63:0] out_mant;
    logic [6:0]  out_lzc;
    logic        out_zero;
    logic        out_denorm;

    int nvec = 0;
    int nerr = 0;

    fp_norm_shift_64 #(.EXP_W(11)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_mant   (out_mant),
        .out_lzc    (out_lzc),
        .out_zero   (out_zero),
        .out_denorm (out_denorm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [10:0] exp;
        logic [63:0] mant;
        logic [6:0]  lzc;
        logic        zero;
        logic        denorm;
    } res_t;

    typedef struct {
        logic        isign;
        logic [10:0] iexp;
        logic [63:0] imant;
        logic [10:0] oexp;
        logic [63:0] omant;
        logic [6:0]  olzc;
        logic        ozero;
        logic        odenorm;
    } vec_t;

    vec_t vecs[10];

    // Reference: count zeros from the MSB, then apply the exponent rules directly.
    function automatic res_t model(input logic s, input logic [10:0] e, input logic [63:0] m);
        res_t r;
        int   lz;
        int   ee;
        bit   found;
        lz    = 64;
        found = 0;
        for (int i = 63; i >= 0; i--) begin
            if (!found && m[i]) begin
                lz    = 63 - i;
                found = 1;
            end
        end
        ee       = int'(e);
        r.sign   = s;
        r.lzc    = 7'(lz);
        r.zero   = 1'b0;
        r.denorm = 1'b0;
        if (m == 64'd0) begin
            r.zero = 1'b1;
            r.mant = 64'd0;
            r.exp  = 11'd0;
        end else if (lz == 0) begin
            r.mant = m;
            r.exp  = e;
        end else if (lz < ee) begin
            r.mant = m << lz;
            r.exp  = 11'(ee - lz);
        end else begin
            r.mant   = m << ((ee == 0) ? 0 : ee - 1);
            r.exp    = 11'd0;
            r.denorm = 1'b1;
        end
        return r;
    endfunction

    task automatic check_res(input string name, input res_t e);
        nvec++;
        if (!out_valid || out_sign !== e.sign || out_exp !== e.exp || out_mant !== e.mant ||
            out_lzc !== e.lzc || out_zero !== e.zero || out_denorm !== e.denorm) begin
            nerr++;
            $display("FAIL %s: got v=%0b s=%0b exp=%0d mant=%h lzc=%0d z=%0b d=%0b, want v=1 s=%0b exp=%0d mant=%h lzc=%0d z=%0b d=%0b",
                     name, out_valid, out_sign, out_exp, out_mant, out_lzc, out_zero, out_denorm,
                     e.sign, e.exp, e.mant, e.lzc, e.zero, e.denorm);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Offer one operand with out_ready high, then check 2-edge latency and result.
    task automatic send_and_check(input string name, input logic s, input logic [10:0] e,
                                  input logic [63:0] m, input res_t want);
        int w;
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        out_ready = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check_val({name, "_latency"}, 64'(lat), 64'd2);
        check_res(name, want);
    endtask

    task automatic gen(output logic s, output logic [10:0] e, output logic [63:0] m);
        int          k;
        int          sel;
        logic [63:0] r;
        s = 1'($urandom_range(0, 1));
        k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(40, 64)) : int'($urandom_range(0, 64));
        r = {$urandom, $urandom};
        r[63] = 1'b1;
        m = (k == 64) ? 64'd0 : (r >> k);
        sel = int'($urandom_range(0, 9));
        if (sel < 3) e = 11'(k);
        else if (sel < 7) e = 11'($urandom_range(0, 70));
        else e = 11'($urandom_range(0, 2047));
    endtask

    // Stream n random operands against a scoreboard queue; returns cycle count.
    task automatic run_stream(input int n, input bit rnd_ready, output int cycles);
        res_t        q[$];
        int          sent;
        int          guard;
        bit          have;
        logic        cs;
        logic [10:0] ce;
        logic [63:0] cm;
        res_t        front;
        sent   = 0;
        guard  = 0;
        have   = 0;
        cycles = 0;
        while ((sent < n || q.size() > 0) && guard < n * 20 + 100) begin
            @(negedge clk);
            if (sent < n && !have) begin
                gen(cs, ce, cm);
                have = 1;
            end
            in_valid  = have;
            in_sign   = cs;
            in_exp    = ce;
            in_mant   = cm;
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_val("stream_unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    front = q.pop_front();
                    check_res("stream", front);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(cs, ce, cm));
                sent++;
                have = 0;
            end
            cycles++;
            guard++;
        end
        if (sent < n || q.size() > 0) begin
            check_val("stream_timeout_pending", 64'(q.size() + n - sent), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        res_t ea;
        res_t eb;
        res_t ec;
        res_t ef;
        res_t want;
        int   cyc;

        vecs[0] = '{0, 11'd100,  64'h0000_0001_0000_0000, 11'd69,   64'h8000_0000_0000_0000, 7'd31, 0, 0};
        vecs[1] = '{1, 11'd10,   64'h0000_0000_0000_00FF, 11'd0,    64'h0000_0000_0001_FE00, 7'd56, 0, 1};
        vecs[2] = '{0, 11'd0,    64'h0000_0000_0000_0001, 11'd0,    64'h0000_0000_0000_0001, 7'd63, 0, 1};
        vecs[3] = '{1, 11'd500,  64'h0000_0000_0000_0000, 11'd0,    64'h0000_0000_0000_0000, 7'd64, 1, 0};
        vecs[4] = '{0, 11'd3,    64'h8000_0000_0000_0001, 11'd3,    64'h8000_0000_0000_0001, 7'd0,  0, 0};
        vecs[5] = '{1, 11'd63,   64'h0000_0000_0000_0001, 11'd0,    64'h4000_0000_0000_0000, 7'd63, 0, 1};
        vecs[6] = '{0, 11'd64,   64'h0000_0000_0000_0001, 11'd1,    64'h8000_0000_0000_0000, 7'd63, 0, 0};
        vecs[7] = '{1, 11'd0,    64'hC000_0000_0000_0000, 11'd0,    64'hC000_0000_0000_0000, 7'd0,  0, 0};
        vecs[8] = '{0, 11'd2047, 64'h0000_0000_0000_0F00, 11'd1995, 64'hF000_0000_0000_0000, 7'd52, 0, 0};
        vecs[9] = '{1, 11'd1,    64'h0000_0000_0000_0010, 11'd0,    64'h0000_0000_0000_0010, 7'd59, 0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check_val("reset_out_valid", 64'(out_valid), 64'd0);
        check_val("reset_in_ready", 64'(in_ready), 64'd1);
        check_val("reset_out_mant", out_mant, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            want.sign   = vecs[i].isign;
            want.exp    = vecs[i].oexp;
            want.mant   = vecs[i].omant;
            want.lzc    = vecs[i].olzc;
            want.zero   = vecs[i].ozero;
            want.denorm = vecs[i].odenorm;
            send_and_check($sformatf("table%0d", i), vecs[i].isign, vecs[i].iexp,
                           vecs[i].imant, want);
        end

        // Backpressure: two accepted, third blocked, first result held stable
        ea = model(1'b0, 11'd100, 64'h0000_0001_0000_0000);
        eb = model(1'b1, 11'd10, 64'h0000_0000_0000_00FF);
        ec = model(1'b0, 11'd3, 64'h8000_0000_0000_0001);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sign = 1'b0; in_exp = 11'd100; in_mant = 64'h0000_0001_0000_0000;
        #1 check_val("bp_ready_a", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_sign = 1'b1; in_exp = 11'd10; in_mant = 64'h0000_0000_0000_00FF;
        #1 check_val("bp_ready_b", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_sign = 1'b0; in_exp = 11'd3; in_mant = 64'h8000_0000_0000_0001;
        #1 check_val("bp_ready_c_blocked", 64'(in_ready), 64'd0);
        check_res("bp_first_out", ea);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check_val("bp_stall_ready", 64'(in_ready), 64'd0);
            check_res("bp_stall_hold", ea);
        end
        out_ready = 1'b1;
        #1 check_val("bp_release_ready", 64'(in_ready), 64'd1);
        check_res("bp_out_a", ea);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check_res("bp_out_b", eb);
        @(posedge clk);
        @(negedge clk);
        #1 check_res("bp_out_c", ec);
        @(posedge clk);
        @(negedge clk);
        #1 check_val("bp_no_dup", 64'(out_valid), 64'd0);

        // Reset with two entries in flight
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        in_sign = 1'b1; in_exp = 11'd40; in_mant = 64'h0000_00FF_0000_0000;
        @(posedge clk);
        @(negedge clk);
        in_sign = 1'b0; in_exp = 11'd7; in_mant = 64'h0000_0000_0000_0003;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_mid_out_mant", out_mant, 64'd0);
        check_val("rst_mid_out_exp", 64'(out_exp), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check_val("rst_discard", 64'(out_valid), 64'd0);
        end
        ef = model(1'b1, 11'd20, 64'h0000_0000_0001_0000);
        send_and_check("post_reset", 1'b1, 11'd20, 64'h0000_0000_0001_0000, ef);

        // Random stream with random backpressure, then full-rate stream
        run_stream(1000, 1'b1, cyc);
        run_stream(50, 1'b0, cyc);
        check_val("full_rate_cycles", 64'(cyc), 64'd52);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fp_norm_shift_64.md
Name: fp_norm_shift_64

Overview:
Post-adder normalization stage for the 64-bit mantissa datapath.
- Accepts an unnormalized mantissa and its biased exponent.
- Computes the leading-zero count with an internal lza_64 instance.
- Left-shifts the mantissa to normalize it and adjusts the exponent, clamping to the denormal range when needed.
- Two-stage pipeline with valid/ready handshake on both sides; sits between the mantissa adder and the rounding stage.

Parameters:
EXP_W, 11, width of the biased exponent field (unsigned).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream operand valid.
in_ready  output  1  block can accept an operand this cycle.
in_sign  input  1  operand sign, passed through.
in_exp  input  EXP_W  biased exponent of the unnormalized mantissa.
in_mant  input  64  unnormalized mantissa.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_sign  output  1  sign, passed through.
out_exp  output  EXP_W  adjusted biased exponent.
out_mant  output  64  normalized (or denormal-clamped) mantissa.
out_lzc  output  7  raw leading-zero count, 0..64.
out_zero  output  1  mantissa was all zero.
out_denorm  output  1  result clamped to denormal (out_exp = 0).

Behaviour:
Transfer rules:
- An input transfer occurs when in_valid && in_ready.
- An output transfer occurs when out_valid && out_ready.

Stage 1 (S1):
- On an input transfer, registers sign, exp and mant together with lzc = lza_64(in_mant).
- lzc = 64 when in_mant = 0.

Stage 2 (S2):
- Computes shift amount, out_exp, out_mant and flags from the S1 contents.
- Registers them onto the out_* ports.

Shift and exponent rules, applied in this priority:
- mant == 0: out_zero = 1, out_mant = 0, out_exp = 0, out_denorm = 0, out_lzc = 64.
- lzc == 0: no shift; out_exp = in_exp; out_denorm = 0.
- lzc < in_exp: shift = lzc; out_exp = in_exp - lzc; out_denorm = 0.
- lzc >= in_exp (including in_exp = 0): shift = (in_exp == 0) ? 0 : in_exp - 1; out_exp = 0; out_denorm = 1.
- out_mant = mant << shift, logical shift with zero fill. Shift amount is at most 63; bits shifted out are never nonzero.
- out_lzc always reports the raw count, independent of clamping.

Pipeline and handshake:
- Each stage holds one entry with its own valid bit.
- S2 advances when !s2_valid || out_ready.
- S1 advances into S2 when s1_valid && S2 advances.
- in_ready = !s1_valid || (S1 advances into S2). in_ready is combinational from out_ready; no combinational path from in_valid to in_ready.
- Latency is 2 cycles from an input transfer to out_valid when out_ready stays high. Throughput is 1 result per cycle.
- While out_valid && !out_ready, all out_* signals hold stable.
- Simultaneous input and output transfer in the same cycle is legal; no bubble is inserted.
- Results emerge strictly in input order, with no loss or duplication.

Reset:
- rst_n low immediately clears s1_valid, s2_valid and out_valid, and zeroes all out_* data.
- in_ready is 1 after reset.
- Entries in flight at reset are discarded and never emitted.
- Operation resumes on the first clk edge after rst_n deasserts.

Test Plan:
- Normal shift: mant=0x0000_0001_0000_0000, exp=100 -> two cycles later out_lzc=31, out_mant=0x8000_0000_0000_0000, out_exp=69, out_denorm=0, out_zero=0.
- Denormal clamp: mant=0x0000_0000_0000_00FF, exp=10 -> out_lzc=56, shift 9, out_mant=0x0000_0000_0001_FE00, out_exp=0, out_denorm=1. Also exp=0, mant=0x1 -> out_mant=0x1, out_exp=0, out_denorm=1.
- Zero and passthrough: mant=0, exp=500 -> out_zero=1, out_mant=0, out_exp=0, out_lzc=64. mant=0x8000_0000_0000_0001, exp=3 -> unchanged, out_lzc=0, out_denorm=0.
- Backpressure: hold out_ready=0 and offer 3 operands back-to-back -> first 2 accepted, then in_ready=0. The first result holds stable on out_* for the full stall. Raising out_ready delivers all 3 in order on consecutive cycles with no duplication.
- Reset mid-operation: 2 entries in flight, pulse rst_n low between clock edges -> out_valid drops asynchronously, in_ready=1 after reset, neither entry appears afterwards. A new operand then completes with normal 2-cycle latency.
- Streaming: 1000 random operands (biased toward large lzc, small exp, and lzc == exp), in_valid=1, out_ready randomly toggled -> every result matches the reference model, in order. With out_ready held at 1, sustained rate is 1 result per cycle.
